// File: rtl/cache_test_mem_responder_pkg.sv
// Shared widths, request encodings and FSM states for the cache-test memory responder.
// Also holds the line-range check used on the response path.
package cache_test_mem_responder_pkg;

  localparam int unsigned BUS_64              = 64;
  localparam int unsigned BUS_512             = 512;
  localparam int unsigned CACHE_LINE_OFFSET_W = 6;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam logic [BUS_64-1:0] PC_START = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP,
    ST_DONE
  } resp_state_e;

  // Addresses below base would wrap in the subtraction, so they are rejected explicitly.
  function automatic logic addr_in_range(input logic [BUS_64-1:0] addr,
                                         input logic [BUS_64-1:0] base,
                                         input int unsigned       idx_w);
    logic [BUS_64-1:0] off;
    off = addr - base;
    return (addr >= base) && ((off >> (CACHE_LINE_OFFSET_W + idx_w)) == '0);
  endfunction

endpackage

// File: rtl/cache_test_mem_responder_if.sv
// Cache-test request/response bus: the initiator drives the request side,
// the responder returns a one-cycle ack with read data and an error flag.
interface cache_test_mem_responder_if;
  import cache_test_mem_responder_pkg::*;

  logic               cache_test_req;
  logic [BUS_64-1:0]  cache_test_addr;
  logic               cache_test_op;
  logic [BUS_512-1:0] cache_test_wdata;
  logic               cache_test_ack;
  logic [BUS_512-1:0] cache_test_rdata;
  logic               cache_test_err;

  modport master (
    output cache_test_req, cache_test_addr, cache_test_op, cache_test_wdata,
    input  cache_test_ack, cache_test_rdata, cache_test_err
  );

  modport slave (
    input  cache_test_req, cache_test_addr, cache_test_op, cache_test_wdata,
    output cache_test_ack, cache_test_rdata, cache_test_err
  );

endinterface

// File: rtl/cache_test_mem_responder_mem_array.sv
// Line storage for the responder: synchronous write, combinational read,
// valid bits cleared on reset so untouched lines read as zero.
module cache_test_mem_array
  import cache_test_mem_responder_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IDX_W-1:0]   widx,
  input  logic [BUS_512-1:0] wdata,
  input  logic [IDX_W-1:0]   ridx,
  output logic [BUS_512-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [BUS_512-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   valid;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[widx] <= 1'b1;
    end
  end

  assign rdata = valid[ridx] ? mem[ridx] : '0;

endmodule

// File: rtl/cache_test_mem_responder.sv
// Behavioural 512-bit-line memory with fixed request-to-ack latency, one
// transaction in flight; stands in for the cache path in standalone tests.
module cache_test_mem_responder
  import cache_test_mem_responder_pkg::*;
#(
  parameter int unsigned       LATENCY   = 4,
  parameter int unsigned       IDX_W     = 6,
  parameter logic [BUS_64-1:0] BASE_ADDR = PC_START
) (
  input logic                  clk,
  input logic                  rst,
  cache_test_mem_responder_if.slave bus
);

  resp_state_e        state;
  logic [7:0]         cnt;
  logic [BUS_64-1:0]  lat_addr;
  logic               lat_op;
  logic [BUS_512-1:0] lat_wdata;

  logic               ack_q;
  logic               err_q;
  logic [BUS_512-1:0] rdata_q;

  logic               resp_entry;
  logic [BUS_64-1:0]  cur_addr;
  logic               cur_op;
  logic [BUS_512-1:0] cur_wdata;
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  logic               wr_en;
  logic [BUS_512-1:0] arr_rdata;

  // BUSY spans LATENCY-1 cycles, so RESP is entered as cnt steps 1->0; with
  // LATENCY==1 the accept edge is itself the RESP-entry edge and uses the live inputs.
  always_comb begin
    resp_entry = 1'b0;
    cur_addr   = lat_addr;
    cur_op     = lat_op;
    cur_wdata  = lat_wdata;
    case (state)
      ST_IDLE: begin
        if (LATENCY == 1 && bus.cache_test_req) begin
          resp_entry = 1'b1;
          cur_addr   = bus.cache_test_addr;
          cur_op     = bus.cache_test_op;
          cur_wdata  = bus.cache_test_wdata;
        end
      end
      ST_BUSY: resp_entry = (cnt <= 8'd1);
      default: resp_entry = 1'b0;
    endcase
  end

  always_comb begin
    in_range = addr_in_range(cur_addr, BASE_ADDR, IDX_W);
    idx      = IDX_W'((cur_addr - BASE_ADDR) >> CACHE_LINE_OFFSET_W);
    wr_en    = resp_entry && (cur_op == REQ_WRITE) && in_range && !rst;
  end

  cache_test_mem_array #(
    .IDX_W (IDX_W)
  ) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .widx  (idx),
    .wdata (cur_wdata),
    .ridx  (idx),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      lat_addr <= '0;
      lat_op   <= REQ_READ;
    end else begin
      ack_q <= resp_entry;
      err_q <= resp_entry && !in_range;
      if (resp_entry && cur_op == REQ_READ) begin
        rdata_q <= in_range ? arr_rdata : '0;
      end

      case (state)
        ST_IDLE: begin
          if (bus.cache_test_req) begin
            lat_addr  <= bus.cache_test_addr;
            lat_op    <= bus.cache_test_op;
            lat_wdata <= bus.cache_test_wdata;
            cnt       <= 8'(LATENCY - 1);
            state     <= (LATENCY == 1) ? ST_RESP : ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 8'd1;
          end
          if (resp_entry) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cache_test_ack   = ack_q;
  assign bus.cache_test_err   = err_q;
  assign bus.cache_test_rdata = rdata_q;

endmodule
